// File: rtl/sb_pkg.sv
// Shared types and sizing constants for the posted-write store buffer.
// One entry holds a buffered store: its valid bit, word address and data.
package sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  function automatic int sb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SB_PTR_W = sb_ptr_w(SB_DEPTH);
  localparam int SB_CNT_W = SB_PTR_W + 1;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Finds the youngest valid buffered store whose address equals addr_i.
// Purely combinational; entries are scanned oldest-first so the last hit is the youngest.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                  ents_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [$clog2(DEPTH):0]     count_i,
  input  logic [SB_ADDR_W-1:0]       addr_i,
  output logic                       hit_o,
  output logic [SB_DATA_W-1:0]       data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walking head..tail-1 and letting later hits overwrite earlier ones is the
  // same as a backwards priority search from tail-1; pointers wrap for free.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if ((CNT_W'(k) < count_i) && ents_i[idx].valid && (ents_i[idx].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = ents_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the control stage and data memory: queues stores,
// drains one per idle memory cycle, and forwards the youngest buffered data to loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memWrite,
  input  logic                   memRead,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      writeData,
  output logic                   stall,
  output logic [DATA_W-1:0]      readData,
  output logic                   fwd_hit,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [ADDR_W-1:0]      dm_address,
  output logic [DATA_W-1:0]      dm_writeData,
  output logic                   dm_memWrite,
  input  logic [DATA_W-1:0]      dm_readData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        ents_q [DEPTH];
  sb_entry_t        ents_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             drain;
  logic             accept;
  logic             fwd_match;
  logic [DATA_W-1:0] fwd_data;

  // Loads own the single memory port; a drain only happens on cycles without one.
  assign drain  = (count_q != '0) && !memRead;
  assign accept = memWrite && ((count_q < CNT_W'(DEPTH)) || drain);

  sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .ents_i  (ents_q),
    .head_i  (head_q),
    .count_i (count_q),
    .addr_i  (address),
    .hit_o   (fwd_match),
    .data_o  (fwd_data)
  );

  // When full, push and pop hit the same slot; the push is applied last and wins.
  always_comb begin
    ents_d  = ents_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      ents_d[head_q].valid = 1'b0;
      head_d               = head_q + 1'b1;
    end
    if (accept) begin
      ents_d[tail_q] = '{valid: 1'b1, addr: address, data: writeData};
      tail_d         = tail_q + 1'b1;
    end
    case ({accept, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ents_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ents_q  <= ents_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of the clock.
  always_comb begin
    stall        = 1'b0;
    fwd_hit      = 1'b0;
    readData     = '0;
    dm_memWrite  = 1'b0;
    dm_address   = '0;
    dm_writeData = '0;
    if (rst) begin
      stall = memWrite && !accept;
      if (memRead) begin
        dm_address = address;
        fwd_hit    = fwd_match;
        readData   = fwd_match ? fwd_data : dm_readData;
      end else if (drain) begin
        dm_address   = ents_q[head_q].addr;
        dm_writeData = ents_q[head_q].data;
        dm_memWrite  = 1'b1;
      end else begin
        dm_address = address;
      end
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain, forwarding, full/stall, wrap-around.
// Memory writes are logged at each rising edge and compared against expected order.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        memWrite;
  logic        memRead;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        stall;
  logic [31:0] readData;
  logic        fwd_hit;
  logic        empty;
  logic [2:0]  count;
  logic [31:0] dm_address;
  logic [31:0] dm_writeData;
  logic        dm_memWrite;
  logic [31:0] dm_readData;

  int tests;
  int fails;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  store_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .address      (address),
    .writeData    (writeData),
    .stall        (stall),
    .readData     (readData),
    .fwd_hit      (fwd_hit),
    .empty        (empty),
    .count        (count),
    .dm_address   (dm_address),
    .dm_writeData (dm_writeData),
    .dm_memWrite  (dm_memWrite),
    .dm_readData  (dm_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_memWrite === 1'b1) begin
      log_a.push_back(dm_address);
      log_d.push_back(dm_writeData);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    memWrite = 1'b1; memRead = 1'b1; address = 32'h44; writeData = 32'h5;
    #3;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b exp 0", stall); end
    tests++; if (fwd_hit !== 1'b0) begin fails++; $display("FAIL rst_fwd_hit got %b exp 0", fwd_hit); end
    tests++; if (readData !== 32'h0) begin fails++; $display("FAIL rst_readData got %h exp 0", readData); end
    tests++; if (dm_memWrite !== 1'b0) begin fails++; $display("FAIL rst_dm_memWrite got %b exp 0", dm_memWrite); end
    tests++; if (dm_address !== 32'h0) begin fails++; $display("FAIL rst_dm_address got %h exp 0", dm_address); end
    tests++; if (dm_writeData !== 32'h0) begin fails++; $display("FAIL rst_dm_writeData got %h exp 0", dm_writeData); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b exp 1", empty); end
    tick();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    rst = 1'b1; memWrite = 1'b0; memRead = 1'b0;
    tick();
  endtask

  task automatic test_reset_pending();
    memRead = 1'b1; memWrite = 1'b1; address = 32'h30; writeData = 32'h1;
    tick();
    address = 32'h34; writeData = 32'h2;
    tick();
    memWrite = 1'b0;
    #1;
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL pend_count got %0d exp 2", count); end
    memRead = 1'b0;
    #1;
    tests++; if (dm_memWrite !== 1'b1) begin fails++; $display("FAIL pend_drain_ready got %b exp 1", dm_memWrite); end
    rst = 1'b0;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL pend_rst_count got %0d exp 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL pend_rst_empty got %b exp 1", empty); end
    tests++; if (dm_memWrite !== 1'b0) begin fails++; $display("FAIL pend_rst_dm_memWrite got %b exp 0", dm_memWrite); end
    tick();
    rst = 1'b1;
    log_a.delete(); log_d.delete();
    repeat (4) tick();
    tests++; if (log_a.size() != 0) begin fails++; $display("FAIL pend_discarded_writes got %0d exp 0", log_a.size()); end
  endtask

  task automatic test_store_idle();
    log_a.delete(); log_d.delete();
    memWrite = 1'b1; memRead = 1'b0; address = 32'h10; writeData = 32'hDEADBEEF;
    #1;
    tests++; if (dm_memWrite !== 1'b0) begin fails++; $display("FAIL idle_no_bypass got %b exp 0", dm_memWrite); end
    tick();
    memWrite = 1'b0; address = 32'h0; writeData = 32'h0;
    #1;
    tests++; if (dm_memWrite !== 1'b1) begin fails++; $display("FAIL idle_dm_memWrite got %b exp 1", dm_memWrite); end
    tests++; if (dm_address !== 32'h10) begin fails++; $display("FAIL idle_dm_address got %h exp 10", dm_address); end
    tests++; if (dm_writeData !== 32'hDEADBEEF) begin fails++; $display("FAIL idle_dm_writeData got %h exp deadbeef", dm_writeData); end
    tick();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL idle_empty got %b exp 1", empty); end
    tests++; if (log_a.size() != 1) begin fails++; $display("FAIL idle_write_count got %0d exp 1", log_a.size()); end
  endtask

  task automatic test_forward();
    log_a.delete(); log_d.delete();
    memRead = 1'b1; memWrite = 1'b1; address = 32'h20; writeData = 32'h1111;
    tick();
    writeData = 32'h2222;
    #1;
    tests++; if (readData !== 32'h1111 || fwd_hit !== 1'b1) begin fails++; $display("FAIL fwd_same_cycle got %h/%b exp 1111/1", readData, fwd_hit); end
    tick();
    memWrite = 1'b0;
    #1;
    tests++; if (fwd_hit !== 1'b1) begin fails++; $display("FAIL fwd_hit got %b exp 1", fwd_hit); end
    tests++; if (readData !== 32'h2222) begin fails++; $display("FAIL fwd_youngest got %h exp 2222", readData); end
    tests++; if (dm_memWrite !== 1'b0 || dm_address !== 32'h20) begin fails++; $display("FAIL fwd_port got %b/%h exp 0/20", dm_memWrite, dm_address); end
    address = 32'h24;
    #1;
    tests++; if (fwd_hit !== 1'b0 || readData !== 32'hCAFEF00D) begin fails++; $display("FAIL fwd_miss got %b/%h exp 0/cafef00d", fwd_hit, readData); end
    memRead = 1'b0;
    #1;
    tests++; if (readData !== 32'h0 || fwd_hit !== 1'b0) begin fails++; $display("FAIL fwd_noread got %h/%b exp 0/0", readData, fwd_hit); end
    tick(); tick(); tick();
    exp_a = '{32'h20, 32'h20};
    exp_d = '{32'h1111, 32'h2222};
    tests++; if (log_a.size() != 2) begin fails++; $display("FAIL fwd_drain_count got %0d exp 2", log_a.size()); end
    for (int i = 0; i < 2 && i < log_a.size(); i++) begin
      tests++;
      if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
        fails++; $display("FAIL fwd_drain_%0d got %h/%h exp %h/%h", i, log_a[i], log_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_full();
    log_a.delete(); log_d.delete();
    memRead = 1'b1; memWrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = 32'h100 + 32'(4 * i); writeData = 32'hA0 + 32'(i);
      tick();
    end
    address = 32'h110; writeData = 32'hA4;
    #1;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count got %0d exp 4", count); end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall got %b exp 1", stall); end
    tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_stall_count got %0d exp 4", count); end
    memRead = 1'b0;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL full_pushpop_stall got %b exp 0", stall); end
    tests++; if (dm_memWrite !== 1'b1 || dm_address !== 32'h100) begin fails++; $display("FAIL full_pushpop_port got %b/%h exp 1/100", dm_memWrite, dm_address); end
    tick();
    memWrite = 1'b0; memRead = 1'b1; address = 32'h100;
    #1;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_pushpop_count got %0d exp 4", count); end
    tests++; if (fwd_hit !== 1'b0 || readData !== 32'hCAFEF00D) begin fails++; $display("FAIL full_popped_miss got %b/%h exp 0/cafef00d", fwd_hit, readData); end
    address = 32'h110;
    #1;
    tests++; if (fwd_hit !== 1'b1 || readData !== 32'hA4) begin fails++; $display("FAIL full_new_hit got %b/%h exp 1/a4", fwd_hit, readData); end
    memRead = 1'b0;
    repeat (4) tick();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_drained_empty got %b exp 1", empty); end
    tests++; if (log_a.size() != 5) begin fails++; $display("FAIL full_write_count got %0d exp 5", log_a.size()); end
    for (int i = 0; i < 5 && i < log_a.size(); i++) begin
      tests++;
      if (log_a[i] !== 32'h100 + 32'(4 * i) || log_d[i] !== 32'hA0 + 32'(i)) begin
        fails++; $display("FAIL full_order_%0d got %h/%h exp %h/%h", i, log_a[i], log_d[i], 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_wrap();
    log_a.delete(); log_d.delete();
    for (int k = 0; k < 6; k++) begin
      memWrite = 1'b1; memRead = 1'b0; address = 32'h200 + 32'(4 * k); writeData = 32'hB000 + 32'(k);
      tick();
      memWrite = 1'b0; memRead = 1'b1;
      #1;
      tests++;
      if (fwd_hit !== 1'b1 || readData !== 32'hB000 + 32'(k)) begin
        fails++; $display("FAIL wrap_fwd_%0d got %b/%h exp 1/%h", k, fwd_hit, readData, 32'hB000 + 32'(k));
      end
      tick();
      memRead = 1'b0;
      tick();
    end
    memRead = 1'b1; memWrite = 1'b1; address = 32'h300;
    for (int k = 0; k < 3; k++) begin
      writeData = 32'hC0 + 32'(k);
      tick();
    end
    memWrite = 1'b0;
    #1;
    tests++; if (fwd_hit !== 1'b1 || readData !== 32'hC2) begin fails++; $display("FAIL wrap_youngest got %b/%h exp 1/c2", fwd_hit, readData); end
    address = 32'h204;
    #1;
    tests++; if (fwd_hit !== 1'b0) begin fails++; $display("FAIL wrap_drained_miss got %b exp 0", fwd_hit); end
    memRead = 1'b0;
    repeat (4) tick();
    tests++; if (log_a.size() != 9) begin fails++; $display("FAIL wrap_write_count got %0d exp 9", log_a.size()); end
    for (int i = 0; i < 9 && i < log_a.size(); i++) begin
      logic [31:0] ea, ed;
      ea = (i < 6) ? 32'h200 + 32'(4 * i) : 32'h300;
      ed = (i < 6) ? 32'hB000 + 32'(i) : 32'hC0 + 32'(i - 6);
      tests++;
      if (log_a[i] !== ea || log_d[i] !== ed) begin
        fails++; $display("FAIL wrap_order_%0d got %h/%h exp %h/%h", i, log_a[i], log_d[i], ea, ed);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; memWrite = 1'b0; memRead = 1'b0;
    address = 32'h0; writeData = 32'h0; dm_readData = 32'hCAFEF00D;
    test_reset();
    test_reset_pending();
    test_store_idle();
    test_forward();
    test_full();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the ALU/control stage and the data memory.
- Accepts stores in one cycle and queues them in a small circular FIFO.
- Drains one queued store per cycle into the data memory whenever the memory's single address port is not needed by a load.
- Forwards the youngest matching buffered store data to loads, so a load never returns stale memory contents.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- memWrite  in  1  store request from the control stage this cycle.
- memRead  in  1  load request from the control stage this cycle.
- address  in  ADDR_W  load/store word address from the ALU.
- writeData  in  DATA_W  store data.
- stall  out  1  store request not accepted this cycle; the core must hold the instruction.
- readData  out  DATA_W  load result delivered to writeback.
- fwd_hit  out  1  readData was sourced from the buffer.
- empty  out  1  no pending stores.
- count  out  $clog2(DEPTH)+1  number of pending stores.
- dm_address  out  ADDR_W  data memory address.
- dm_writeData  out  DATA_W  data memory write data.
- dm_memWrite  out  1  data memory write enable.
- dm_readData  in  DATA_W  data memory read data (combinational read).

Behaviour:
- Reset (rst low, asynchronous): head=0, tail=0, count=0, all entry valid bits cleared; pending stores are discarded.
- While in reset: stall=0, fwd_hit=0, readData=0, dm_memWrite=0, dm_address=0, dm_writeData=0, empty=1.
- Storage: DEPTH entries of {addr, data}. Head is the oldest entry, tail the next free slot. Pointers wrap modulo DEPTH; count disambiguates full from empty.
- Port arbitration (combinational):
  - drain = !empty && !memRead.
  - If memRead: dm_address=address, dm_memWrite=0.
  - Else if drain: dm_address=entry[head].addr, dm_writeData=entry[head].data, dm_memWrite=1.
  - Else: dm_memWrite=0, dm_address=address.
- Pop: when drain is true, the head entry is invalidated at the rising edge and head increments.
- Push: accept = memWrite && (count<DEPTH || drain).
  - On accept, {address, writeData} is written to entry[tail] at the rising edge and tail increments.
  - stall = memWrite && !accept.
- Count update: count += accept - drain. Simultaneous push and pop when full is legal; count stays DEPTH.
- Latency: an accepted store reaches memory no earlier than the next cycle. There is no bypass from push straight to memory.
- Forwarding (combinational):
  - Compare the full-width address against every valid entry.
  - The youngest match (closest to tail-1, searching backwards with wrap) wins.
  - fwd_hit=memRead && match; readData = fwd_hit ? matched data : dm_readData.
  - readData=0 when !memRead.
- Store and load in the same cycle: forwarding sees only entries present before the edge; the same-cycle store is not visible.
- Multiple stores to the same address: all are kept and drained in order. Memory ends with the youngest value; forwarding returns the youngest.
- A continuous load stream starves draining. There is no fairness requirement; the core stalls only on a store while full.

Decomposition:
- Shared package sb_pkg: SB_DEPTH default, ADDR_W/DATA_W constants, typedef sb_entry_t {logic valid; addr; data}, pointer and count width constants.
- One sub-module, sb_match: takes the entry array, head, and count; outputs hit plus data of the youngest matching entry (priority search from tail-1 with wrap).

Test Plan:
- Reset with entries pending: push 2 stores, assert rst low mid-cycle -> immediately count=0, empty=1, dm_memWrite=0; after release, no write of the discarded stores ever appears.
- Store then idle: sw 0x10<-0xDEADBEEF with memRead=0 -> next cycle dm_memWrite=1, dm_address=0x10, dm_writeData=0xDEADBEEF; the cycle after, empty=1.
- Forwarding priority: hold memRead=1 to block draining; push 0x20<-0x1111 then 0x20<-0x2222; load 0x20 -> fwd_hit=1, readData=0x2222; load 0x24 -> fwd_hit=0, readData=dm_readData.
- Full and stall: hold memRead=1, push 4 stores -> count=4; 5th store with memRead=1 -> stall=1, count stays 4; same 5th store with memRead=0 -> stall=0, drain and push together, count stays 4.
- Wrap-around: push/drain 6 stores alternating with idle cycles -> memory receives all 6 in order with correct data; pointers wrap past DEPTH-1 and forwarding still hits the youngest entry.
